fbf_lane_adder: RTL
===================

Name: fbf_lane_adder

Overview:
- Elementwise IEEE-754 single-precision adder for a 4x4 block of floats (16 lanes of 32 bits).
- Sits directly downstream of the block multiplier. The matrix controller feeds it the current partial-sum C block (A) and the multiplier's product block (B), then reads back the accumulated C block.
- Uses one shared add datapath, iterated over the 16 lanes. This trades latency for area.
- Handshake follows the multiplier/adder convention: A_stb/B_stb in, result_ready/result_ack out.

Parameters:
- LANES, 16, number of 32-bit lanes per block (4x4).
- WORD, 32, lane width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- A_stb  input  1  operand A valid.
- B_stb  input  1  operand B valid.
- A  input  LANES*WORD  operand block A; lane k is bits [32k+31:32k], k = 4*row + col.
- B  input  LANES*WORD  operand block B; same packing as A.
- result_ack  input  1  consumer has taken the result.
- result_ready  output  1  result is valid and held.
- result  output  LANES*WORD  sum block; same packing as A.
- busy  output  1  high from capture until return to IDLE.

Behaviour:
- Reset: result_ready=0, busy=0, result=0, state=IDLE.
  - Reset asserted mid-operation aborts immediately; the partial result is discarded.
- IDLE: capture A and B into internal registers on the first edge where A_stb && B_stb = 1.
  - With only one strobe high, remain in IDLE and capture nothing.
  - After capture, set busy=1, lane=0, go to UNPACK.
- Per-lane pipeline, one state per cycle, 5 cycles per lane:
  - UNPACK: split sign, exponent and mantissa; restore the hidden bit; flag zero/subnormal/Inf/NaN.
  - ALIGN: swap so that |x| >= |y|. Right-shift the smaller mantissa by the exponent difference and keep guard/round/sticky. A shift of 27 or more collapses the operand to sticky only.
  - ADD: add or subtract mantissas according to the sign XOR. The result sign is that of the larger-magnitude operand.
  - NORM: single-cycle normalise with a priority encoder. Carry-out gives a right shift by 1; otherwise left shift by the leading-zero count. Adjust the exponent to match.
  - ROUND: round to nearest, ties to even. Handle mantissa overflow after rounding. Write the lane into the internal sum buffer.
    - If lane < 15: lane+1, go to UNPACK.
    - Else: go to DONE.
- Latency: with the capture edge counted as edge 0, result and result_ready update on edge 80.
  - result is copied from the sum buffer at that edge as one 512-bit update.
- DONE: hold result_ready=1 and keep result stable.
  - On an edge with result_ack=1: result_ready=0, busy=0, go to IDLE.
  - result keeps its value until the next completion.
- Back-to-back operation: a strobe still high when IDLE is re-entered starts a new capture on the next edge. No new capture is accepted while busy.
- Changes on A/B after capture are ignored.
- Special cases, applied per lane:
  - Subnormal inputs are treated as zero with their sign kept.
  - A result below the minimum normal flushes to zero with its sign kept.
  - Exponent overflow, including after rounding, gives signed Inf.
  - Any NaN input, or Inf + (-Inf), gives 0x7FC00000.
  - Inf + finite gives that Inf.
  - An exact-zero difference (x + -x) gives +0 (0x00000000).
  - (-0) + (-0) gives 0x80000000.

Test Plan:
- Basic add and timing: every lane A=0x3F800000, B=0x40000000 -> all lanes 0x40400000. result_ready rises on edge 80 after capture and stays high until result_ack; busy drops on the ack edge.
- Cancellation and signed zero: lane0 1.0 + 0xBF800000 -> 0x00000000; lane1 0x80000000 + 0x80000000 -> 0x80000000; lane2 0x00000001 + 0x00000000 -> 0x00000000 (flush).
- Specials: lane0 0x7F800000 + 0xFF800000 -> 0x7FC00000; lane1 0x7FC00001 + 1.0 -> 0x7FC00000; lane2 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; lane3 0x7F800000 + 5.0 -> 0x7F800000.
- Rounding:
  - lane0 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even).
  - lane1 0x3F800000 + 0x33C00000 -> 0x3F800001.
  - lane2 0x3F800001 + 0x33800000 -> 0x3F800002 (tie to even, rounding up).
- Handshake and reset:
  - A_stb=1 with B_stb=0 for 10 cycles -> no capture, busy=0.
  - Strobes held high through an ack -> second capture on the edge after the return to IDLE.
  - reset pulsed at cycle 40 of an operation -> result=0, result_ready=0, IDLE; a fresh operation then completes correctly.
- Per-lane independence: lane k gets A = k as float, B = 16.0 (0x41800000) -> lane k result = (k+16) as float; e.g. lane 15 = 0x41F80000.

Source files
------------

// File: rtl/fbf_lane_adder.sv
// Elementwise single-precision adder over a 4x4 block of floats. One shared
// five-stage add datapath is iterated over all lanes, one stage per cycle.
module fbf_lane_adder #(
  parameter int LANES = 16,
  parameter int WORD  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   A_stb,
  input  logic                   B_stb,
  input  logic [LANES*WORD-1:0]  A,
  input  logic [LANES*WORD-1:0]  B,
  input  logic                   result_ack,
  output logic                   result_ready,
  output logic [LANES*WORD-1:0]  result,
  output logic                   busy,
  output logic [2:0]             state_dbg
);

  localparam int LW = $clog2(LANES);

  // Handshake: A and B are captured on the first IDLE edge with A_stb && B_stb;
  // result_ready stays high with result held until an edge with result_ack.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    NORM   = 3'd4,
    ROUND  = 3'd5,
    DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        z;
    logic        inf;
    logic        nan;
  } op_t;

  state_t                  state;
  logic [LW-1:0]           lane;
  logic [LANES*WORD-1:0]   a_reg, b_reg, sum_buf;

  op_t                     x_r, y_r;
  logic [26:0]             big_r, sml_r;
  logic signed [9:0]       exp_r;
  logic                    sign_r, sub_r, spec_r;
  logic [31:0]             spec_val_r;
  logic [27:0]             sum_r;
  logic [26:0]             nm_r;
  logic signed [9:0]       ne_r;
  logic                    nz_r;

  assign state_dbg = state;

  // Subnormals are folded into zero here so later stages never see them.
  function automatic op_t unpack(input logic [31:0] w);
    op_t o;
    o.s   = w[31];
    o.z   = (w[30:23] == 8'd0);
    o.e   = o.z ? 8'd0 : w[30:23];
    o.m   = o.z ? 24'd0 : {1'b1, w[22:0]};
    o.inf = (w[30:23] == 8'hFF) && (w[22:0] == 23'd0);
    o.nan = (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    return o;
  endfunction

  op_t   ux_c, uy_c;
  always_comb begin
    ux_c = unpack(a_reg[lane*WORD +: WORD]);
    uy_c = unpack(b_reg[lane*WORD +: WORD]);
  end

  op_t         bg_c, sm_c;
  logic [7:0]  diff_c;
  logic [49:0] ext_c;
  logic [26:0] sml_al_c;
  logic        spec_c;
  logic [31:0] spec_val_c;
  always_comb begin
    if ({x_r.e, x_r.m} >= {y_r.e, y_r.m}) begin
      bg_c = x_r;
      sm_c = y_r;
    end else begin
      bg_c = y_r;
      sm_c = x_r;
    end
    diff_c = bg_c.e - sm_c.e;
    ext_c  = {sm_c.m, 26'd0} >> diff_c;
    if (diff_c >= 8'd27) sml_al_c = {26'd0, |sm_c.m};
    else                 sml_al_c = {ext_c[49:24], |ext_c[23:0]};
    spec_c     = 1'b1;
    spec_val_c = 32'd0;
    if (x_r.nan || y_r.nan || (x_r.inf && y_r.inf && (x_r.s != y_r.s)))
      spec_val_c = 32'h7FC00000;
    else if (x_r.inf)
      spec_val_c = {x_r.s, 8'hFF, 23'd0};
    else if (y_r.inf)
      spec_val_c = {y_r.s, 8'hFF, 23'd0};
    else if (x_r.z && y_r.z)
      spec_val_c = {x_r.s & y_r.s, 31'd0};
    else
      spec_c = 1'b0;
  end

  logic [27:0] sum_c;
  always_comb begin
    if (sub_r) sum_c = {1'b0, big_r} - {1'b0, sml_r};
    else       sum_c = {1'b0, big_r} + {1'b0, sml_r};
  end

  // Priority encoder: the highest set bit is visited last and wins.
  logic [4:0]        lz_c;
  logic [26:0]       nm_c;
  logic signed [9:0] ne_c;
  always_comb begin
    lz_c = 5'd27;
    for (int i = 0; i < 27; i++)
      if (sum_r[i]) lz_c = 5'(26 - i);
    if (sum_r[27]) begin
      nm_c = {sum_r[27:2], |sum_r[1:0]};
      ne_c = exp_r + 10'sd1;
    end else begin
      nm_c = sum_r[26:0] << lz_c;
      ne_c = exp_r - $signed({5'd0, lz_c});
    end
  end

  logic              up_c;
  logic [24:0]       m25_c;
  logic [23:0]       rm_c;
  logic signed [9:0] re_c;
  logic [31:0]       rnd_c;
  logic [LANES*WORD-1:0] buf_n;
  always_comb begin
    up_c  = nm_r[2] & (nm_r[1] | nm_r[0] | nm_r[3]);
    m25_c = {1'b0, nm_r[26:3]} + {24'd0, up_c};
    rm_c  = m25_c[24] ? m25_c[24:1] : m25_c[23:0];
    re_c  = ne_r + $signed({9'd0, m25_c[24]});
    if (spec_r)               rnd_c = spec_val_r;
    else if (nz_r)            rnd_c = 32'd0;
    else if (re_c >= 10'sd255) rnd_c = {sign_r, 8'hFF, 23'd0};
    else if (re_c <= 10'sd0)  rnd_c = {sign_r, 31'd0};
    else                      rnd_c = {sign_r, re_c[7:0], rm_c[22:0]};
    buf_n = sum_buf;
    buf_n[lane*WORD +: WORD] = rnd_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lane         <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      sum_buf      <= '0;
      result       <= '0;
      result_ready <= 1'b0;
      busy         <= 1'b0;
      x_r          <= '0;
      y_r          <= '0;
      big_r        <= '0;
      sml_r        <= '0;
      exp_r        <= '0;
      sign_r       <= 1'b0;
      sub_r        <= 1'b0;
      spec_r       <= 1'b0;
      spec_val_r   <= '0;
      sum_r        <= '0;
      nm_r         <= '0;
      ne_r         <= '0;
      nz_r         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (A_stb && B_stb) begin
            a_reg <= A;
            b_reg <= B;
            lane  <= '0;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          x_r   <= ux_c;
          y_r   <= uy_c;
          state <= ALIGN;
        end
        ALIGN: begin
          big_r      <= {bg_c.m, 3'b000};
          sml_r      <= sml_al_c;
          exp_r      <= {2'b00, bg_c.e};
          sign_r     <= bg_c.s;
          sub_r      <= x_r.s ^ y_r.s;
          spec_r     <= spec_c;
          spec_val_r <= spec_val_c;
          state      <= ADD;
        end
        ADD: begin
          sum_r <= sum_c;
          state <= NORM;
        end
        NORM: begin
          nm_r  <= nm_c;
          ne_r  <= ne_c;
          nz_r  <= (sum_r == 28'd0);
          state <= ROUND;
        end
        ROUND: begin
          sum_buf <= buf_n;
          if (lane == LW'(LANES - 1)) begin
            result       <= buf_n;
            result_ready <= 1'b1;
            state        <= DONE;
          end else begin
            lane  <= lane + 1'b1;
            state <= UNPACK;
          end
        end
        DONE: begin
          if (result_ack) begin
            result_ready <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
